// File: rtl/dmem_port_arbiter.sv
// Two-port sequencer/arbiter for the 16x8 data memory; every memory-side signal comes from a flop.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins), else round-robin.
module dmem_port_arbiter #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic [AddrW-1:0] addr0_i,
  input  logic [AddrW-1:0] addr1_i,
  input  logic [DataW-1:0] wdata0_i,
  input  logic [DataW-1:0] wdata1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic [DataW-1:0] rdata0_o,
  output logic [DataW-1:0] rdata1_o,
  output logic             busy_o,
  output logic [DataW-1:0] mem_data_in_o,
  output logic [AddrW-1:0] mem_write_select_o,
  output logic [AddrW-1:0] mem_read_select_o,
  output logic             mem_select_o,
  input  logic [DataW-1:0] mem_data_out_i
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e             state_q, state_d;
  logic               start;
  logic               win_port;
  logic               req_any;

  logic               cur_we_q;
  logic [AddrW-1:0]   cur_addr_q;
  logic [DataW-1:0]   cur_wdata_q;
  logic               cur_port_q;

  logic               gnt0_q, gnt1_q, done0_q, done1_q, busy_q, mem_select_q;
  logic [DataW-1:0]   rdata0_q, rdata1_q;

  assign req_any = req0_i | req1_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 0 always wins; port 1 only when port 0 is idle.
  assign win_port = ~req0_i;
`else
  logic last_grant_q;

  assign win_port = (req0_i & req1_i) ? ~last_grant_q : req1_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
    end else if (start) begin
      last_grant_q <= win_port;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StSetup;
          start   = 1'b1;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: state_d = StHold;
      StHold: begin
        if (req_any) begin
          state_d = StSetup;
          start   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      mem_select_q <= 1'b0;
      cur_we_q     <= 1'b0;
      cur_addr_q   <= '0;
      cur_wdata_q  <= '0;
      cur_port_q   <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      gnt0_q  <= start & ~win_port;
      gnt1_q  <= start & win_port;
      // Fields are captured while the requester still holds them stable, so the memory
      // address/data settle a full cycle before the select pulse.
      if (start) begin
        cur_port_q  <= win_port;
        cur_we_q    <= win_port ? we1_i : we0_i;
        cur_addr_q  <= win_port ? addr1_i : addr0_i;
        cur_wdata_q <= win_port ? wdata1_i : wdata0_i;
      end
      mem_select_q <= (state_q == StSetup) & cur_we_q;
      done0_q      <= (state_q == StAccess) & ~cur_port_q;
      done1_q      <= (state_q == StAccess) & cur_port_q;
      if ((state_q == StAccess) && !cur_we_q) begin
        if (cur_port_q) begin
          rdata1_q <= mem_data_out_i;
        end else begin
          rdata0_q <= mem_data_out_i;
        end
      end
    end
  end

  assign gnt0_o             = gnt0_q;
  assign gnt1_o             = gnt1_q;
  assign done0_o            = done0_q;
  assign done1_o            = done1_q;
  assign rdata0_o           = rdata0_q;
  assign rdata1_o           = rdata1_q;
  assign busy_o             = busy_q;
  assign mem_select_o       = mem_select_q;
  assign mem_data_in_o      = cur_wdata_q;
  assign mem_write_select_o = cur_addr_q;
  assign mem_read_select_o  = cur_addr_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 16x8 memory model.
module tb_dmem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, busy, mem_select;
  logic [7:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [3:0] mem_write_select, mem_read_select;

  logic [7:0] mem [16];

  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] exp_rd0, exp_rd1;

  typedef struct {
    logic       port;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_select) mem[mem_write_select] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_read_select];

  dmem_port_arbiter dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .req0_i             (req0),
    .req1_i             (req1),
    .we0_i              (we0),
    .we1_i              (we1),
    .addr0_i            (addr0),
    .addr1_i            (addr1),
    .wdata0_i           (wdata0),
    .wdata1_i           (wdata1),
    .gnt0_o             (gnt0),
    .gnt1_o             (gnt1),
    .done0_o            (done0),
    .done1_o            (done1),
    .rdata0_o           (rdata0),
    .rdata1_o           (rdata1),
    .busy_o             (busy),
    .mem_data_in_o      (mem_data_in),
    .mem_write_select_o (mem_write_select),
    .mem_read_select_o  (mem_read_select),
    .mem_select_o       (mem_select),
    .mem_data_out_i     (mem_data_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"}, {gnt0, gnt1}, 2'b00);
    chk({tag, " done"}, {done0, done1}, 2'b00);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " sel"}, mem_select, 1'b0);
    chk({tag, " wsel"}, mem_write_select, 4'd0);
    chk({tag, " rsel"}, mem_read_select, 4'd0);
    chk({tag, " din"}, mem_data_in, 8'd0);
    chk({tag, " rdata0"}, rdata0, 8'd0);
    chk({tag, " rdata1"}, rdata1, 8'd0);
  endtask

  // One isolated transaction from IDLE, checking each phase.
  task automatic do_txn(input vec_t v);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    tick();  // SETUP
    chk("setup gnt", {gnt1, gnt0}, v.port ? 2'b10 : 2'b01);
    chk("setup busy", busy, 1'b1);
    chk("setup sel", mem_select, 1'b0);
    if (v.we) chk("setup wsel", mem_write_select, v.addr);
    req0 = 1'b0; req1 = 1'b0;
    tick();  // ACCESS
    chk("access gnt", {gnt1, gnt0}, 2'b00);
    chk("access sel", mem_select, v.we);
    chk("access wsel", mem_write_select, v.addr);
    chk("access rsel", mem_read_select, v.addr);
    if (v.we) chk("access din", mem_data_in, v.wdata);
    chk("access done", {done1, done0}, 2'b00);
    tick();  // HOLD
    chk("hold done", {done1, done0}, v.port ? 2'b10 : 2'b01);
    chk("hold sel", mem_select, 1'b0);
    chk("hold wsel", mem_write_select, v.addr);
    if (v.we) chk("hold din", mem_data_in, v.wdata);
    if (!v.we) begin
      if (v.port) exp_rd1 = v.exp_rdata;
      else exp_rd0 = v.exp_rdata;
    end
    chk("hold rdata0", rdata0, exp_rd0);
    chk("hold rdata1", rdata1, exp_rd1);
    tick();  // IDLE
    chk("idle busy", busy, 1'b0);
    chk("idle done", {done1, done0}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'd7,  8'h55, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'd7,  8'h00, 8'h55};
    vecs[2] = '{1'b1, 1'b1, 4'd15, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 4'd0,  8'h3C, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 4'd0,  8'h00, 8'h3C};
    vecs[6] = '{1'b1, 1'b1, 4'd2,  8'h11, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 4'd9,  8'h99, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 4'd2,  8'h00, 8'h11};
    vecs[9] = '{1'b1, 1'b0, 4'd9,  8'h00, 8'h99};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post-reset idle");

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Both ports requesting continuously: port 0 reads 2, port 1 reads 9.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
    for (int k = 1; k <= 18; k++) begin
      logic       g_exp;
      logic [1:0] gv;
      tick();
      g_exp = ((k - 1) % 3) == 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gv = g_exp ? 2'b01 : 2'b00;
`else
      gv = !g_exp ? 2'b00 : ((((k - 1) / 3) % 2) == 0 ? 2'b01 : 2'b10);
`endif
      chk("rr gnt", {gnt1, gnt0}, gv);
      chk("rr sel", mem_select, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr idle", busy, 1'b0);
    chk("rr rdata0", rdata0, 8'h11);
    chk("rr rdata1", rdata1, 8'h99);

    // Reset during the ACCESS cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 8'hA0;
    tick();
    chk("abort gnt", gnt0, 1'b1);
    req0 = 1'b0;
    tick();
    chk("abort access sel", mem_select, 1'b1);
    reset = 1'b1;
    tick();
    chk_all_zero("abort");
    reset = 1'b0;
    tick();
    chk("abort no done", {done1, done0}, 2'b00);
    chk("abort mem0", mem[0], 8'hA0);
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    do_txn('{1'b1, 1'b0, 4'd0, 8'h00, 8'hA0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequencer and two-port arbiter for the 16×8 data memory. It shares the memory's single write/read port between requester 0 (CPU load/store unit) and requester 1 (debug/loader port). The memory writes combinationally whenever its select is high, so this block drives every memory-side signal from flops. Address and data are held stable one cycle before and one cycle after each select pulse.

## Interface
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 8, memory word width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  word address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, fields latched
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DATA_W  read result; updated only on that port's read completion, then held
- busy  out  1  high in any state other than IDLE
- mem_data_in  out  DATA_W  to memory data_in
- mem_write_select  out  ADDR_W  to memory write_select
- mem_read_select  out  ADDR_W  to memory read_select
- mem_select  out  1  to memory select (write strobe)
- mem_data_out  in  DATA_W  from memory data_out

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. All outputs are registered.
- IDLE: if req0 or req1 is high, arbitrate and go to SETUP. Otherwise stay in IDLE.
- Arbitration is round-robin on a 1-bit last_grant pointer.
  - If both requesters are high, the port that is not last_grant wins.
  - If only one is high, that port wins.
  - last_grant is set to the winner on every grant.
- SETUP:
  - Latch the winner's we/addr/wdata into cur_we/cur_addr/cur_wdata. Latch the winner's id into cur_port.
  - Pulse gnt of the winner. mem_select stays 0.
  - mem_write_select, mem_read_select and mem_data_in show the latched values from the next cycle onward.
- ACCESS:
  - mem_select = cur_we.
  - mem_read_select = cur_addr.
  - On exit, capture mem_data_out into rdata[cur_port] if cur_we = 0.
- HOLD:
  - mem_select = 0. Address and data are unchanged.
  - Pulse done[cur_port].
  - Next state is SETUP (new arbitration) if any req is high; otherwise IDLE.
- A requester may deassert req or change its fields on the cycle after its gnt.
- Arithmetic: none. Addresses pass through unmodified; all 16 addresses (0–15) are valid and there is no wrap logic.

## Timing
- Reset values:
  - State IDLE, last_grant = 1, so port 0 wins the first tie.
  - gnt0/1 = 0, done0/1 = 0, busy = 0, mem_select = 0.
  - mem_* address/data = 0, rdata0/1 = 0.
- Latency, with req sampled high in IDLE at edge N:
  - gnt at cycle N+1 (SETUP).
  - mem_select high during N+2 (ACCESS).
  - done and valid rdata at N+3 (HOLD).
- Throughput is one access per 3 cycles under back-to-back load (HOLD→SETUP, no IDLE bubble). With both ports continuously requesting, grants alternate 0,1,0,1…
- mem_select is high for exactly one cycle per write and never high for reads. Address and data are stable for the whole SETUP+1 … HOLD window.
- A req arriving during SETUP/ACCESS/HOLD waits; it is never dropped.
- A request deasserted before its gnt is simply not served (no error).
- Reset mid-operation: the next edge forces IDLE and the reset values above.
  - A write whose ACCESS cycle already occurred stays in memory.
  - No done pulse is issued for the aborted access.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. Port 0 always wins when both request; last_grant is unused. Port 1 can starve.
  - Undefined (default): round-robin as above.

## Test plan
- After reset: all outputs 0, busy = 0.
- req0 write addr 7, data 0x55:
  - gnt0 at +1, mem_select high only at +2 with mem_write_select = 7, done0 at +3.
  - A following read of addr 7 on port 1 returns rdata1 = 0x55.
- req0 and req1 held high (port 0 reads addr 2, port 1 reads addr 9; memory preloaded 0x11/0x99):
  - Grants alternate 0,1,0,1 with 3-cycle spacing.
  - rdata0 = 0x11, rdata1 = 0x99.
- Same stimulus with DMEM_ARB_FIXED_PRIO_EN defined: gnt0 every 3 cycles, gnt1 never.
- Port 1 write 0xFF to addr 15 while mem_select is monitored: exactly one select pulse, and write_select/data_in do not change in the cycles before and after it.
- Assert reset during ACCESS of a write of 0xA0 to addr 0:
  - Next cycle: IDLE, mem_select = 0, no done.
  - Memory[0] reads 0xA0 afterwards.
